fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter and occupancy controller placed in front of the single-clock `FIFO` block. It shares the FIFO's one write port between `N_REQ` requesters and gates the consumer's read requests. It tracks occupancy itself, because the FIFO exposes no full or empty flag. It drives the FIFO's `wr_en`, `din` and `rd_en` directly; the FIFO's `n_rst` is tied to `~rst`.

## Interface

Parameters:
- `N_REQ`, 4: number of write requesters, at least 2.
- `DATA_WIDTH`, 8: data word width.
- `FIFO_DEPTH`, 4: FIFO address bits. Capacity `CAP` = 2**FIFO_DEPTH = 16 entries.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  N_REQ  per-requester write request.
- `req_data`  in  N_REQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  N_REQ  one-hot grant pulse, registered.
- `rd_req`  in  1  consumer read request.
- `fifo_wr_en`  out  1  to FIFO `wr_en`, registered.
- `fifo_din`  out  DATA_WIDTH  to FIFO `din`, registered.
- `fifo_rd_en`  out  1  to FIFO `rd_en`, registered.
- `count`  out  FIFO_DEPTH+1  number of entries issued to the FIFO.
- `full`  out  1  `count == CAP`.
- `empty`  out  1  `count == 0`.

## Operation

- Reset values: `gnt`, `fifo_wr_en`, `fifo_rd_en` and `fifo_din` are 0; `count` is 0, so `empty`=1 and `full`=0; the round-robin pointer `last` is N_REQ-1, which gives requester 0 first priority.
- Eligible requesters are `elig = req & ~gnt`. A requester whose grant pulse is active this cycle is masked out, so it is never double-granted while it drops `req`.
- Read acceptance: `rd_acc = rd_req && count != 0`. A read from an empty FIFO is never issued, even if a write is accepted in the same cycle.
- Write acceptance: `wr_acc = |elig && (count < CAP || rd_acc)`. At `full`, a write is accepted only when a read is accepted in the same cycle.
- Winner: the first set bit of `elig`, searching cyclically from `last+1`.
- At each rising edge:
  - `fifo_wr_en <= wr_acc`, `fifo_rd_en <= rd_acc`.
  - If `wr_acc`: `fifo_din <=` the winner's word, `gnt <=` onehot(winner), `last <=` winner.
  - Otherwise: `gnt <= 0`, and `fifo_din` holds its value.
  - `count <= count + wr_acc - rd_acc`. Width is FIFO_DEPTH+1 bits; `count` never wraps and never exceeds `CAP`.
- Requester rule: hold `req` and data until `gnt[i]` is seen. Data may change, or `req` may drop, from the cycle after the `gnt[i]` pulse.
- Consumer rule: a read is honoured only when `empty`=0 is seen. Refused reads are dropped, not queued. The FIFO's `dout` is consumed per the FIFO's own read latency.
- Reset mid-operation: everything returns to reset values immediately. In-flight grants are lost; requesters re-request. The FIFO is reset concurrently.

## Timing

- `req` sampled at edge k produces `gnt`, `fifo_wr_en` and `fifo_din` in the cycle after edge k. That is 1 cycle of latency.
- `count`, `full` and `empty` update at the same edge that registers the FIFO operation, one cycle ahead of the FIFO's internal state.
- Because reads and writes share the same 1-cycle issue delay, FIFO ordering is preserved and the FIFO never over- or under-flows.
- Throughput: one write per cycle across all requesters. Any single requester gets at most one grant every 2 cycles.
- No combinational path exists from `req` or `rd_req` to any output except through registers. `full` and `empty` decode the `count` register.

## Structure

- Shared package `fifo_pkg` holds:
  - default `DATA_WIDTH` and `FIFO_DEPTH` constants;
  - the `CAP` computation (2**FIFO_DEPTH);
  - the count width FIFO_DEPTH+1.
  - The FIFO and its bench use the same package.
- Sub-module `rr_arbiter`: combinational, parameter `N`. Inputs are `elig[N]` and `last`; outputs are `win_onehot` and `win_idx`. Used once, for the write port.
- The top level holds the registers, occupancy counter, acceptance logic and data mux.

## Test plan

- Reset, then `req`=4'b0001 with data 0x11 → one cycle later `gnt`=0001, `fifo_wr_en`=1, `fifo_din`=0x11, `count`=1. No re-grant in the next cycle, even with `req` still high.
- `req`=4'b1111 held continuously with data 0x10..0x13 → grant order 0,1,2,3,0,…, with at most one write per cycle and FIFO contents in grant order.
- Fill to 16 with `rd_req`=0 → `full`=1, `gnt` stays 0, and the 17th requester keeps `req` high with no write issued.
- At `full` with `req` and `rd_req` both high → `fifo_wr_en`=1, `fifo_rd_en`=1, `count` stays at 16.
- `rd_req`=1 while `empty` with `req`=0001 in the same cycle → write issued, no read issued, `count`=1. A read issued on the following request returns the written word.
- Assert `rst` mid-burst at `count`=7 → all outputs 0 and `count`=0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing constants and helpers
package fifo_pkg;

  // Default word width and address bits for the FIFO and its front end
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Number of entries for a given address width
  function automatic int cap_of(input int depth);
    return 1 << depth;
  endfunction

  // Occupancy counter width: one extra bit so a full FIFO is representable
  function automatic int count_width(input int depth);
    return depth + 1;
  endfunction

  localparam int DEF_CAP = cap_of(DEF_FIFO_DEPTH);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  win_onehot,
  output logic [LW-1:0] win_idx
);

  logic          found;
  logic [LW-1:0] k;

  // Scan cyclically starting just after the previous winner; first hit wins
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    k          = '0;
    for (int i = 1; i <= N; i++) begin
      k = LW'((int'(last) + i) % N);
      if (!found && elig[k]) begin
        found         = 1'b1;
        win_idx       = k;
        win_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter and occupancy tracker for the FIFO
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        rd_req,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic                        fifo_rd_en,
  output logic [FIFO_DEPTH:0]         count,
  output logic                        full,
  output logic                        empty
);

  localparam int CW  = count_width(FIFO_DEPTH);
  localparam int CAP = cap_of(FIFO_DEPTH);
  localparam int LW  = $clog2(N_REQ);

  logic [LW-1:0]         last;
  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      win_onehot;
  logic [LW-1:0]         win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  rd_acc;
  logic                  wr_acc;

  // A requester whose grant pulse is showing is masked so it is not granted twice
  assign elig = req & ~gnt;

  rr_arbiter #(
    .N  (N_REQ),
    .LW (LW)
  ) u_rr (
    .elig       (elig),
    .last       (last),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // Acceptance: never read when empty; at full a write needs a same-cycle read
  always_comb begin
    rd_acc = rd_req && (count != '0);
    wr_acc = (|elig) && ((count < CW'(CAP)) || rd_acc);
  end

  // Data mux selecting the winner's word
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Issue registers, round-robin pointer and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_din   <= '0;
      count      <= '0;
      last       <= LW'(N_REQ - 1);
    end else begin
      fifo_wr_en <= wr_acc;
      fifo_rd_en <= rd_acc;
      count      <= count + CW'(wr_acc) - CW'(rd_acc);
      if (wr_acc) begin
        fifo_din <= win_data;
        gnt      <= win_onehot;
        last     <= win_idx;
      end else begin
        gnt <= '0;
      end
    end
  end

  assign full  = (count == CW'(CAP));
  assign empty = (count == '0);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rd_req;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        fifo_rd_en;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [4:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        rd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  fifo_wr_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .rd_req     (rd_req),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_rd_en (fifo_rd_en),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".gnt"},   32'(gnt),        32'(e.gnt));
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(e.wr));
    chk({tag, ".din"},   32'(fifo_din),   32'(e.din));
    chk({tag, ".rd_en"}, 32'(fifo_rd_en), 32'(e.rd));
    chk({tag, ".count"}, 32'(count),      32'(e.cnt));
    chk({tag, ".full"},  32'(full),       32'(e.cnt == 5'd16));
    chk({tag, ".empty"}, 32'(empty),      32'(e.cnt == 5'd0));
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [31:0] d,
                      input logic rd, input exp_t e);
    req      = r;
    req_data = d;
    rd_req   = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".gnt"},   32'(gnt),        32'h0);
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'h0);
    chk({tag, ".din"},   32'(fifo_din),   32'h0);
    chk({tag, ".rd_en"}, 32'(fifo_rd_en), 32'h0);
    chk({tag, ".count"}, 32'(count),      32'h0);
    chk({tag, ".full"},  32'(full),       32'h0);
    chk({tag, ".empty"}, 32'(empty),      32'h1);
  endtask

  localparam logic [31:0] RR_DATA = 32'h13121110;

  initial begin
    exp_t e;
    int   n;

    // req, req_data, rd_req, {gnt, wr_en, din, rd_en, count}
    vecs[0]  = '{4'b0001, 32'h00000011, 1'b0, '{4'b0001, 1'b1, 8'h11, 1'b0, 5'd1}};
    vecs[1]  = '{4'b0001, 32'h00000011, 1'b0, '{4'b0000, 1'b0, 8'h11, 1'b0, 5'd1}};
    vecs[2]  = '{4'b0000, 32'h00000000, 1'b1, '{4'b0000, 1'b0, 8'h11, 1'b1, 5'd0}};
    vecs[3]  = '{4'b0001, 32'h00000011, 1'b1, '{4'b0001, 1'b1, 8'h11, 1'b0, 5'd1}};
    vecs[4]  = '{4'b0000, 32'h00000000, 1'b1, '{4'b0000, 1'b0, 8'h11, 1'b1, 5'd0}};
    vecs[5]  = '{4'b1111, RR_DATA,      1'b0, '{4'b0010, 1'b1, 8'h11, 1'b0, 5'd1}};
    vecs[6]  = '{4'b1111, RR_DATA,      1'b0, '{4'b0100, 1'b1, 8'h12, 1'b0, 5'd2}};
    vecs[7]  = '{4'b1111, RR_DATA,      1'b0, '{4'b1000, 1'b1, 8'h13, 1'b0, 5'd3}};
    vecs[8]  = '{4'b1111, RR_DATA,      1'b0, '{4'b0001, 1'b1, 8'h10, 1'b0, 5'd4}};
    vecs[9]  = '{4'b1111, RR_DATA,      1'b0, '{4'b0010, 1'b1, 8'h11, 1'b0, 5'd5}};
    vecs[10] = '{4'b0000, RR_DATA,      1'b1, '{4'b0000, 1'b0, 8'h11, 1'b1, 5'd4}};
    vecs[11] = '{4'b0001, RR_DATA,      1'b1, '{4'b0001, 1'b1, 8'h10, 1'b1, 5'd4}};

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    rd_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].rd, vecs[i].e);
    end

    // From reset, all four requesting: grants rotate 0,1,2,3,... until full
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = '{4'(1 << (k % 4)), 1'b1, 8'(8'h10 + (k % 4)), 1'b0, 5'(k + 1)};
      step($sformatf("fill%0d", k), 4'b1111, RR_DATA, 1'b0, e);
    end

    // Full: requests remain pending, no write issued
    for (int k = 0; k < 3; k++) begin
      e = '{4'b0000, 1'b0, 8'h13, 1'b0, 5'd16};
      step($sformatf("stall%0d", k), 4'b1111, RR_DATA, 1'b0, e);
    end

    // Full with read and write together: both issue, count stays at capacity
    e = '{4'b0001, 1'b1, 8'h10, 1'b1, 5'd16};
    step("full_rw", 4'b1111, RR_DATA, 1'b1, e);

    // Drain down to 7 entries
    n = 16;
    for (int k = 0; k < 9; k++) begin
      n--;
      e = '{4'b0000, 1'b0, 8'h10, 1'b1, 5'(n)};
      step($sformatf("drain%0d", k), 4'b0000, RR_DATA, 1'b1, e);
    end

    // Asynchronous reset mid-burst clears everything without waiting for a clock
    req    = 4'b1111;
    rd_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // Requester 0 has first priority after reset
    e = '{4'b0001, 1'b1, 8'h10, 1'b0, 5'd1};
    step("post_rst", 4'b1111, RR_DATA, 1'b0, e);
    e = '{4'b0010, 1'b1, 8'h11, 1'b0, 5'd2};
    step("post_rst2", 4'b1111, RR_DATA, 1'b0, e);

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
